conv_host_mem: RTL
==================

// Module: conv_host_mem
// PURPOSE
// Memory-side responder for the convolution accelerator interface. Holds the
// 64x64 image buffer, serves iaddr/idata reads, and accepts layer writes and
// reads on cwr/crd/csel into the L0 (conv+ReLU) and L1 (max-pool) banks.
// Runs the ready/busy start handshake and signals completion to the host.
// Host-side load and dump ports fill the image and check results.
// PARAMETERS
// DW          20    data word width (signed, 4.16 fixed point; stored raw)
// AW          12    address width for iaddr/caddr_wr/caddr_rd/load/dump
// IMG_DEPTH   4096  image buffer words
// L0_DEPTH    4096  L0 bank words (csel=3'b001)
// L1_DEPTH    1024  L1 bank words (csel=3'b011)
// HS_TIMEOUT  16    max cycles ready may be held without busy rising
// PORTS
// clk        in   1   clock; all state updates on posedge
// reset      in   1   synchronous, active-high reset
// ready      out  1   start request to accelerator
// busy       in   1   accelerator busy
// iaddr      in   AW  image read address
// idata      out  DW  image word at iaddr (combinational)
// cwr        in   1   layer write strobe
// caddr_wr   in   AW  layer write address
// cdata_wr   in   DW  layer write data
// crd        in   1   layer read strobe
// caddr_rd   in   AW  layer read address
// cdata_rd   out  DW  layer read data (combinational)
// csel       in   3   bank select: 001=L0, 011=L1, others invalid
// load_en    in   1   host image write (honoured in IDLE only)
// load_addr  in   AW  host image write address
// load_data  in   DW  host image write data
// start      in   1   host start pulse (honoured in IDLE only)
// done       out  1   one-cycle pulse after busy falls
// dump_sel   in   1   0=L0, 1=L1 for dump read
// dump_addr  in   AW  dump read address
// dump_data  out  DW  bank word at dump_addr (combinational)
// err        out  1   sticky error flag, cleared by reset or start
// l0_wr_cnt  out  13  accepted L0 writes since start
// l1_wr_cnt  out  11  accepted L1 writes since start
// BEHAVIOUR
// - Reset: ready=0, done=0, err=0, counters=0, FSM=IDLE. Array contents are
//   retained (not cleared). Reset mid-RUN aborts to IDLE; no done pulse.
// - FSM: IDLE -start-> HS (ready=1; clears err and counters). HS -busy=1->
//   RUN (ready=0 the same edge). HS: if busy stays 0 for HS_TIMEOUT cycles,
//   set err and return to IDLE with ready=0. RUN -busy=0-> DONE.
//   DONE: done=1 for one cycle, then IDLE.
// - Reads: idata=img[iaddr], cdata_rd=bank(csel)[caddr_rd] and dump_data are
//   asynchronous. A read from an invalid csel or out-of-depth address returns
//   0. cdata_rd is driven regardless of crd; crd=1 with invalid bank sets err.
// - Writes: on posedge when cwr=1 and state is HS or RUN; csel=001 writes L0,
//   csel=011 writes L1. Invalid csel, address >= bank depth, or cwr outside
//   HS/RUN: write dropped, err set. Each accepted write increments that
//   bank's counter (saturates at its all-ones value).
// - Read and write to the same address in one cycle: the read returns the
//   old word; the new word is visible from the next cycle.
// - load_en outside IDLE, or load_addr >= IMG_DEPTH: dropped, err set.
//   load_en and start in the same IDLE cycle: the load is performed and the
//   FSM enters HS.
// - start outside IDLE is ignored (no err).
// - No arithmetic on data; words are stored and returned bit-exact.
// TESTING
// - Load img[0]=20'h01000, start; hold busy=0 for 16 cycles -> ready=1 for
//   16 cycles, then ready=0, err=1, state IDLE, done never pulses.
// - start; raise busy 2 cycles later -> ready falls on the same edge busy is
//   seen; lower busy 10 cycles later -> done pulses exactly 1 cycle later.
// - In RUN, write csel=001 addr=5 data=20'hABCDE, then crd addr=5 ->
//   cdata_rd=20'hABCDE, l0_wr_cnt=1, and dump_sel=0 addr=5 reads the same.
// - Write csel=011 addr=1024 and csel=010 addr=0 -> both dropped, err=1,
//   l1_wr_cnt=0, L1[0] unchanged.
// - Same-cycle write and read of L1[7] (old=1, new=2) -> cdata_rd=1 in that
//   cycle and 2 in the next.
// - Assert reset mid-RUN with 100 L0 writes done -> ready=0, counters=0,
//   state IDLE, L0[0..99] still readable on dump.

Source files
------------

// File: rtl/conv_host_mem.sv
// conv_host_mem: memory-side responder for the convolution accelerator.
// Holds the image buffer and L0/L1 layer banks, runs the start handshake.
//
// state  | meaning
// S_IDLE | waiting for host start; host loads accepted
// S_HS   | ready=1, waiting for busy (bounded by HS_TIMEOUT)
// S_RUN  | accelerator busy; layer writes accepted
// S_DONE | one-cycle done pulse
module conv_host_mem #(
  parameter int DW         = 20,
  parameter int AW         = 12,
  parameter int IMG_DEPTH  = 4096,
  parameter int L0_DEPTH   = 4096,
  parameter int L1_DEPTH   = 1024,
  parameter int HS_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  output logic          done,
  input  logic          dump_sel,
  input  logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          err,
  output logic [12:0]   l0_wr_cnt,
  output logic [10:0]   l1_wr_cnt
);

  localparam int IMG_IW = $clog2(IMG_DEPTH);
  localparam int L0_IW  = $clog2(L0_DEPTH);
  localparam int L1_IW  = $clog2(L1_DEPTH);
  localparam int HS_CW  = $clog2(HS_TIMEOUT + 1);
  localparam logic [AW:0] IMG_LIM = (AW+1)'(IMG_DEPTH);
  localparam logic [AW:0] L0_LIM  = (AW+1)'(L0_DEPTH);
  localparam logic [AW:0] L1_LIM  = (AW+1)'(L1_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HS, S_RUN, S_DONE} state_t;

  state_t           state, next_state;
  logic [HS_CW-1:0] hs_cnt;
  logic             start_ok, hs_timeout;

  logic [DW-1:0] img [IMG_DEPTH];
  logic [DW-1:0] l0  [L0_DEPTH];
  logic [DW-1:0] l1  [L1_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    hs_timeout = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        next_state = S_HS;
        start_ok   = 1'b1;
      end
      S_HS: begin
        ready = 1'b1;
        if (busy) next_state = S_RUN;
        else if (hs_cnt == '0) begin
          next_state = S_IDLE;
          hs_timeout = 1'b1;
        end
      end
      S_RUN:  if (!busy) next_state = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Down-counter loaded on start; terminal count in HS with busy low is a timeout.
  always_ff @(posedge clk) begin
    if (reset)                            hs_cnt <= '0;
    else if (start_ok)                    hs_cnt <= HS_CW'(HS_TIMEOUT - 1);
    else if (state == S_HS && hs_cnt != '0) hs_cnt <= hs_cnt - 1'b1;
  end

  logic wr_phase, l0_sel, l1_sel;
  logic l0_wr_ok, l1_wr_ok, load_ok;
  logic cwr_bad, load_bad, crd_bad, err_set;

  assign wr_phase = (state == S_HS) || (state == S_RUN);
  assign l0_sel   = (csel == 3'b001);
  assign l1_sel   = (csel == 3'b011);
  assign l0_wr_ok = !reset && cwr && wr_phase && l0_sel && ({1'b0, caddr_wr} < L0_LIM);
  assign l1_wr_ok = !reset && cwr && wr_phase && l1_sel && ({1'b0, caddr_wr} < L1_LIM);
  assign load_ok  = !reset && load_en && (state == S_IDLE) && ({1'b0, load_addr} < IMG_LIM);
  assign cwr_bad  = cwr && !(l0_wr_ok || l1_wr_ok);
  assign load_bad = load_en && !load_ok;
  assign crd_bad  = crd && !(l0_sel || l1_sel);
  assign err_set  = cwr_bad || load_bad || crd_bad || hs_timeout;

  // A start clears err, but an error raised in the same cycle still sticks.
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= (err && !start_ok) || err_set;
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      l0_wr_cnt <= '0;
      l1_wr_cnt <= '0;
    end else begin
      if (l0_wr_ok && l0_wr_cnt != '1) l0_wr_cnt <= l0_wr_cnt + 13'd1;
      if (l1_wr_ok && l1_wr_cnt != '1) l1_wr_cnt <= l1_wr_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok)  img[load_addr[IMG_IW-1:0]] <= load_data;
    if (l0_wr_ok) l0[caddr_wr[L0_IW-1:0]]    <= cdata_wr;
    if (l1_wr_ok) l1[caddr_wr[L1_IW-1:0]]    <= cdata_wr;
  end

  logic [DW-1:0] l0_rd_word, l1_rd_word, l0_dump_word, l1_dump_word;

  assign idata = ({1'b0, iaddr} < IMG_LIM) ? img[iaddr[IMG_IW-1:0]] : '0;

  assign l0_rd_word   = ({1'b0, caddr_rd} < L0_LIM) ? l0[caddr_rd[L0_IW-1:0]] : '0;
  assign l1_rd_word   = ({1'b0, caddr_rd} < L1_LIM) ? l1[caddr_rd[L1_IW-1:0]] : '0;
  assign l0_dump_word = ({1'b0, dump_addr} < L0_LIM) ? l0[dump_addr[L0_IW-1:0]] : '0;
  assign l1_dump_word = ({1'b0, dump_addr} < L1_LIM) ? l1[dump_addr[L1_IW-1:0]] : '0;

  always_comb begin
    cdata_rd = '0;
    if (l0_sel)      cdata_rd = l0_rd_word;
    else if (l1_sel) cdata_rd = l1_rd_word;
  end

  assign dump_data = dump_sel ? l1_dump_word : l0_dump_word;

endmodule
